// File: rtl/spi_dac_pkg.sv
// ============================================================================
// spi_dac_pkg : shared constants and types for the SPI DAC frame receiver
// Revision    : 1.0
// ============================================================================
`default_nettype none

package spi_dac_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;

    localparam int CH_BIT   = 15;
    localparam int BUF_BIT  = 14;
    localparam int GA_BIT   = 13;
    localparam int SHDN_BIT = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_OVERRUN = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0]           ctrl;
        logic [DATA_BITS-1:0] data;
    } chan_reg_t;

    localparam chan_reg_t CHAN_RESET = '{ctrl: 3'b000, data: 12'h000};
    localparam logic [2:0] CTRL_OUT_RESET = 3'b001;

endpackage

`default_nettype wire

// File: rtl/spi_dac_receiver_sync_edge.sv
// ============================================================================
// sync_edge : 2-flop synchronizer plus registered previous value for edges
// Revision  : 1.0
// ============================================================================
`default_nettype none

module sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Resetting to the idle pin level keeps reset release from faking an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

`default_nettype wire

// File: rtl/spi_dac_receiver.sv
// ============================================================================
// spi_dac_receiver : 16-bit SPI frame receiver with dual-channel LDAC latching
// Revision         : 1.0
// ============================================================================
`default_nettype none

module spi_dac_receiver
    import spi_dac_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sck,
    input  logic        sdi,
    input  logic        cs,
    input  logic        ldac,
    output logic [11:0] dac_a_q,
    output logic [11:0] dac_b_q,
    output logic [2:0]  ctrl_a,
    output logic [2:0]  ctrl_b,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [7:0]  err_count
);

    localparam logic [4:0] FULL_CNT = 5'(FRAME_BITS);

    logic w_sck_lvl, w_sck_rise, w_sck_fall;
    logic w_sdi_lvl, w_sdi_rise, w_sdi_fall;
    logic w_cs_lvl,  w_cs_rise,  w_cs_fall;
    logic w_ldac_lvl, w_ldac_rise, w_ldac_fall;
    logic w_unused;

    sync_edge #(.RESET_VAL(1'b1)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .async_i(sck),
        .level_o(w_sck_lvl), .rise_o(w_sck_rise), .fall_o(w_sck_fall)
    );
    sync_edge #(.RESET_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst_n(rst_n), .async_i(sdi),
        .level_o(w_sdi_lvl), .rise_o(w_sdi_rise), .fall_o(w_sdi_fall)
    );
    sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .async_i(cs),
        .level_o(w_cs_lvl), .rise_o(w_cs_rise), .fall_o(w_cs_fall)
    );
    sync_edge #(.RESET_VAL(1'b1)) u_sync_ldac (
        .clk(clk), .rst_n(rst_n), .async_i(ldac),
        .level_o(w_ldac_lvl), .rise_o(w_ldac_rise), .fall_o(w_ldac_fall)
    );

    assign w_unused = &{1'b0, w_sck_lvl, w_sck_fall, w_sdi_rise, w_sdi_fall,
                        w_ldac_lvl, w_ldac_rise};

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] shreg_q, shreg_d;
    chan_reg_t   in_a_q, in_a_d;
    chan_reg_t   in_b_q, in_b_d;
    chan_reg_t   w_new;
    logic        w_good;
    logic        w_bad;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        w_good  = 1'b0;
        w_bad   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    state_d = ST_SHIFT;
                    cnt_d   = 5'd0;
                    shreg_d = 16'h0000;
                end
            end
            ST_SHIFT: begin
                // Frame end takes priority over any bit sampled in the same cycle.
                if (w_cs_rise) begin
                    state_d = ST_IDLE;
                    if (cnt_q == FULL_CNT) begin
                        w_good = 1'b1;
                    end else begin
                        w_bad = 1'b1;
                    end
                end else if (w_sck_rise && !w_cs_lvl) begin
                    if (cnt_q == FULL_CNT) begin
                        state_d = ST_OVERRUN;
                    end else begin
                        shreg_d = {shreg_q[14:0], w_sdi_lvl};
                        cnt_d   = cnt_q + 5'd1;
                    end
                end
            end
            ST_OVERRUN: begin
                if (w_cs_rise) begin
                    state_d = ST_IDLE;
                    w_bad   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_new.ctrl = {shreg_q[BUF_BIT], shreg_q[GA_BIT], shreg_q[SHDN_BIT]};
        w_new.data = shreg_q[DATA_BITS-1:0];
        in_a_d     = (w_good && !shreg_q[CH_BIT]) ? w_new : in_a_q;
        in_b_d     = (w_good &&  shreg_q[CH_BIT]) ? w_new : in_b_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 5'd0;
            shreg_q     <= 16'h0000;
            in_a_q      <= CHAN_RESET;
            in_b_q      <= CHAN_RESET;
            dac_a_q     <= 12'h000;
            dac_b_q     <= 12'h000;
            ctrl_a      <= CTRL_OUT_RESET;
            ctrl_b      <= CTRL_OUT_RESET;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            in_a_q      <= in_a_d;
            in_b_q      <= in_b_d;
            frame_valid <= w_good;
            frame_err   <= w_bad;
            // Latching from the next-state values gives write-through on a coincident frame end.
            if (w_ldac_fall) begin
                dac_a_q <= in_a_d.data;
                ctrl_a  <= in_a_d.ctrl;
                dac_b_q <= in_b_d.data;
                ctrl_b  <= in_b_d.ctrl;
            end
            if (w_bad && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire
